// File: rtl/icache_fetch_responder_pkg.sv
// icache_fetch_responder_pkg: shared widths and refill FSM states for the fetch-side icache
package icache_fetch_responder_pkg;
  localparam int IC_INDEX_BITS = 7;
  localparam int IC_ADDR_W = 32;
  localparam int IC_WORD_W = 32;
  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_FETCH = 2'd1,
    IC_INSTALL = 2'd2
  } ic_state_t;
endpackage

// File: rtl/icache_fetch_responder_line_array.sv
// icache_line_array: valid/tag/data storage with a combinational read port and one write port
module icache_line_array
  import icache_fetch_responder_pkg::*;
#(
  parameter int INDEX_BITS = IC_INDEX_BITS,
  parameter int TAG_W = IC_ADDR_W - IC_INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_ridx,
  output logic                  o_valid,
  output logic [TAG_W-1:0]      o_tag,
  output logic [IC_WORD_W-1:0]  o_data,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_widx,
  input  logic [TAG_W-1:0]      i_wtag,
  input  logic [IC_WORD_W-1:0]  i_wdata
);
  localparam int N = 1 << INDEX_BITS;
  logic [N-1:0]         r_valid;
  logic [TAG_W-1:0]     r_tag  [N];
  logic [IC_WORD_W-1:0] r_data [N];
  assign o_valid = r_valid[i_ridx];
  assign o_tag = r_tag[i_ridx];
  assign o_data = r_data[i_ridx];
  // valid bits are the only reset state; a line becomes valid when installed
  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else if (i_we) r_valid[i_widx] <= 1'b1;
  end
  // tag and data arrays are plain storage, overwritten on every install
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_widx] <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end
endmodule

// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder: direct-mapped one-word-line icache with byte-serial refill
module icache_fetch_responder
  import icache_fetch_responder_pkg::*;
#(
  parameter int INDEX_BITS = IC_INDEX_BITS,
  parameter int ADDR_W = IC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              rdy_o,
  output logic [31:0]       data_o,
  output logic              memReq_o,
  output logic [ADDR_W-1:0] memAddr_o,
  input  logic              memDone_i,
  input  logic [7:0]        memData_i
);
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
  ic_state_t         r_state, w_state;
  logic [1:0]        r_cnt, w_cnt;
  logic [31:0]       r_buf, w_buf;
  logic [ADDR_W-1:0] r_miss, w_miss, r_maddr, w_maddr, w_aligned;
  logic              r_req, w_req;
  logic              w_lvalid, w_hit, w_we;
  logic [TAG_W-1:0]  w_ltag;
  logic [31:0]       w_ldata;
  assign w_aligned = addr_i & ~ADDR_W'(3);
  assign w_hit = w_lvalid && w_ltag == addr_i[ADDR_W-1:INDEX_BITS+2];
  assign w_we = rdy && r_state == IC_INSTALL;
  assign rdy_o = en_i && r_state == IC_IDLE && w_hit;
  assign data_o = w_ldata;
  assign memReq_o = r_req;
  assign memAddr_o = r_maddr;
  icache_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) u_lines (
    .clk(clk),
    .rst(rst),
    .i_ridx(addr_i[INDEX_BITS+1:2]),
    .o_valid(w_lvalid),
    .o_tag(w_ltag),
    .o_data(w_ldata),
    .i_we(w_we),
    .i_widx(r_miss[INDEX_BITS+1:2]),
    .i_wtag(r_miss[ADDR_W-1:INDEX_BITS+2]),
    .i_wdata(r_buf)
  );
  // refill sequencing: start on a miss, gather four little-endian bytes, then install
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_buf = r_buf;
    w_miss = r_miss;
    w_req = r_req;
    w_maddr = r_maddr;
    case (r_state)
      IC_IDLE: if (en_i && !w_hit) begin
        w_miss = w_aligned;
        w_cnt = 2'd0;
        w_req = 1'b1;
        w_maddr = w_aligned;
        w_state = IC_FETCH;
      end
      IC_FETCH: if (memDone_i) begin
        w_buf[8*r_cnt +: 8] = memData_i;
        if (r_cnt == 2'd3) begin
          w_req = 1'b0;
          w_state = IC_INSTALL;
        end else begin
          w_cnt = r_cnt + 2'd1;
          w_maddr = r_miss | ADDR_W'(w_cnt);
        end
      end
      IC_INSTALL: w_state = IC_IDLE;
      default: w_state = IC_IDLE;
    endcase
  end
  // state register; a low global rdy freezes everything except reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IC_IDLE;
      r_cnt <= 2'd0;
      r_buf <= '0;
      r_miss <= '0;
      r_req <= 1'b0;
      r_maddr <= '0;
    end else if (rdy) begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_buf <= w_buf;
      r_miss <= w_miss;
      r_req <= w_req;
      r_maddr <= w_maddr;
    end
  end
endmodule

// File: tb/tb_icache_fetch_responder.sv
// tb_icache_fetch_responder: scoreboard bench with a line-table cache model and a random-latency memory
module tb_icache_fetch_responder;
  logic        clk = 1'b0;
  logic        rst, rdy, en_i, rdy_o, memReq_o, memDone_i;
  logic [31:0] addr_i, data_o, memAddr_o;
  logic [7:0]  memData_i;
  int          checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_q[$];
  logic [7:0]  mem[4096];
  bit          mvalid[128];
  logic [22:0] mtag[128];
  int          k = 0, stall_k = -1, stall_left = 0;
  bit          rand_rdy = 1'b0;

  always #5 clk = ~clk;

  icache_fetch_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .en_i(en_i), .addr_i(addr_i),
    .rdy_o(rdy_o), .data_o(data_o), .memReq_o(memReq_o), .memAddr_o(memAddr_o),
    .memDone_i(memDone_i), .memData_i(memData_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0] & 12'hffc;
    return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
  endfunction

  task automatic model_install(input logic [31:0] a);
    mvalid[a[8:2]] = 1'b1;
    mtag[a[8:2]] = a[31:9];
  endtask

  task automatic model_clear();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input bit chk_hit);
    bit hit, seen;
    int n;
    n = 0;
    hit = mvalid[a[8:2]] && mtag[a[8:2]] == a[31:9];
    exp_q.push_back(word(a));
    if (!hit) req_q.push_back(a & ~32'd3);
    en_i = 1'b1;
    addr_i = a;
    @(negedge clk);
    seen = rdy_o;
    while (!rdy_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_o) begin
      checks++;
      failures++;
      $display("FAIL fetch_timeout addr=%h no rdy_o within %0d cycles", a, n);
    end
    if (chk_hit) chk("hit_same_cycle", {31'd0, seen}, {31'd0, hit});
    model_install(a);
    @(posedge clk);
    #1 en_i = 1'b0;
  endtask

  task automatic wait_k(input int target);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (k != target && n < 400);
    if (k != target) begin
      checks++;
      failures++;
      $display("FAIL wait_bytes actual=%0d required=%0d", k, target);
    end
  endtask

  // global rdy: held high, randomly dropped while rand_rdy is set
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1 rdy = rand_rdy ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
  end

  // memory arbiter model: answers the expected byte address after a random delay
  initial begin
    logic [31:0] t;
    memDone_i = 1'b0;
    memData_i = 8'h00;
    forever begin
      @(negedge clk);
      memDone_i = 1'b0;
      if (rst) k = 0;
      else if (!memReq_o || !rdy) begin
        if ($urandom_range(0, 3) == 0) begin
          memDone_i = 1'b1;
          memData_i = 8'($urandom);
        end
      end else if (req_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_mem_req actual_addr=%h required=no request", memAddr_o);
      end else begin
        t = req_q[0] + 32'(k);
        chk("mem_addr", memAddr_o, t);
        if (k == stall_k && stall_left > 0) stall_left--;
        else if ($urandom_range(0, 2) != 0) begin
          memDone_i = 1'b1;
          memData_i = mem[t[11:0]];
          k++;
          if (k == 4) begin
            k = 0;
            void'(req_q.pop_front());
          end
        end
      end
    end
  end

  // monitor: scoreboard pops on each delivered word, plus hold/exclusion rules
  initial begin
    logic p_rst, p_rdy, p_req, p_done;
    logic [31:0] p_addr, e;
    p_rst = 1'b1;
    p_rdy = 1'b1;
    p_req = 1'b0;
    p_done = 1'b0;
    p_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!p_rst && (!p_rdy || (p_req && !p_done))) begin
        chk("hold_req", {31'd0, memReq_o}, {31'd0, p_req});
        chk("hold_addr", memAddr_o, p_addr);
      end
      if (memReq_o && !rst) chk("no_hit_while_busy", {31'd0, rdy_o}, 32'd0);
      if (en_i && rdy_o && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rdy addr=%h data=%h required=no response", addr_i, data_o);
        end else begin
          e = exp_q.pop_front();
          chk("data", data_o, e);
        end
      end
      p_rst = rst;
      p_rdy = rdy;
      p_req = memReq_o;
      p_done = memDone_i;
      p_addr = memAddr_o;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'h10;
    mem[3] = 8'h00;
    model_clear();
    rst = 1'b1;
    en_i = 1'b0;
    addr_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    en_i = 1'b1;
    addr_i = 32'h0;
    @(negedge clk);
    chk("reset_req", {31'd0, memReq_o}, 32'd0);
    chk("reset_addr", memAddr_o, 32'd0);
    chk("reset_rdy_o", {31'd0, rdy_o}, 32'd0);
    en_i = 1'b0;
    @(posedge clk);
    #1;
    fetch(32'h0, 1'b1);
    chk("cold_word", word(32'h0), 32'h00100513);
    fetch(32'h0, 1'b1);
    stall_k = 2;
    stall_left = 5;
    fetch(32'h4, 1'b1);
    stall_k = -1;
    fetch(32'h4, 1'b1);
    req_q.push_back(32'h8);
    en_i = 1'b1;
    addr_i = 32'h8;
    wait_k(2);
    #1;
    model_install(32'h8);
    fetch(32'h200, 1'b0);
    fetch(32'h8, 1'b1);
    fetch(32'h0, 1'b1);
    fetch(32'h200, 1'b1);
    req_q.push_back(32'h10);
    en_i = 1'b1;
    addr_i = 32'h10;
    wait_k(1);
    #1 rst = 1'b1;
    en_i = 1'b0;
    req_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_mid_fetch_req", {31'd0, memReq_o}, 32'd0);
    chk("rst_mid_fetch_addr", memAddr_o, 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h0, 1'b1);
    fetch(32'h10, 1'b1);
    rand_rdy = 1'b1;
    repeat (300) begin
      a = ($urandom_range(0, 7) << 9) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      fetch(a, 1'b1);
    end
    rand_rdy = 1'b0;
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("mem_queue_empty", req_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
